rpsc_annunciator: RTL and testbench

//  Downstream of the RPSC fault-latch card. Consumes the per-channel lamp-annunciator (LA) latch outputs.

---
 rtl/rpsc_pkg.sv | 13 +
 rtl/rpsc_sync_edge.sv | 33 +++
 rtl/rpsc_annunciator.sv | 113 +++++++++++
 tb/tb_rpsc_annunciator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rpsc_pkg.sv
// Shared types and constants for the RPSC fault annunciator.
// Channel states and the fault-card channel count.
package rpsc_pkg;

   localparam int RPSC_N_FF = 8;

   typedef enum logic [1:0] {
      ANN_NORMAL = 2'd0,
      ANN_ALERT  = 2'd1,
      ANN_STEADY = 2'd2
   } ann_state_e;

endpackage

// File: rtl/rpsc_sync_edge.sv
// Synchronizer for an asynchronous panel input.
// Provides the synchronized level and a registered one-clock pulse per rising edge.
module rpsc_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic [STAGES-1:0] sync_q;
   logic              level_d_q;
   logic              rise_q;

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q    <= '0;
         level_d_q <= 1'b0;
         rise_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[STAGES-2:0], i_async};
         level_d_q <= sync_q[STAGES-1];
         rise_q    <= sync_q[STAGES-1] & ~level_d_q;
      end
   end

   assign o_level = sync_q[STAGES-1];
   assign o_rise  = rise_q;

endmodule

// File: rtl/rpsc_annunciator.sv
// Front-panel annunciator: per-channel flash / acknowledge / steady sequence,
// shared flash phase, horn, lamp test and first-out capture.
module rpsc_annunciator
   import rpsc_pkg::*;
#(
   parameter int N_CH       = RPSC_N_FF,
   parameter int FLASH_HALF = 2500000,
   parameter int SYNC_STG   = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] i_fault_la,
   input  logic            i_ack,
   input  logic            i_lamp_test,
   output logic [N_CH-1:0] o_lamp,
   output logic            o_horn,
   output logic [N_CH-1:0] o_first_out,
   output logic            o_first_valid
);

   localparam int CW = $clog2(FLASH_HALF);

   logic            ack_pulse;
   logic            lamp_test;
   logic            unused_ack_level;
   logic            unused_lt_rise;
   logic [CW-1:0]   flash_cnt_q;
   logic            flash_phase_q;
   logic [N_CH-1:0] alert;
   logic [N_CH-1:0] steady;
   logic [N_CH-1:0] enter;
   logic [N_CH-1:0] nxt_normal;
   logic [N_CH-1:0] enter_low;
   logic [N_CH-1:0] first_q;

   rpsc_sync_edge #(.STAGES(SYNC_STG)) u_ack_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (i_ack),
      .o_level (unused_ack_level),
      .o_rise  (ack_pulse)
   );

   rpsc_sync_edge #(.STAGES(SYNC_STG)) u_lt_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (i_lamp_test),
      .o_level (lamp_test),
      .o_rise  (unused_lt_rise)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flash_cnt_q   <= '0;
         flash_phase_q <= 1'b0;
      end else if (flash_cnt_q == CW'(FLASH_HALF - 1)) begin
         flash_cnt_q   <= '0;
         flash_phase_q <= ~flash_phase_q;
      end else begin
         flash_cnt_q   <= flash_cnt_q + CW'(1);
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      ann_state_e state_q;
      ann_state_e state_d;

      // NOTE: default assignment first keeps this block free of inferred latches.
      always_comb begin
         state_d = state_q;
         case (state_q)
            ANN_ALERT:  if (ack_pulse) state_d = i_fault_la[g] ? ANN_STEADY : ANN_NORMAL;
            ANN_STEADY: if (!i_fault_la[g]) state_d = ANN_NORMAL;
            // NORMAL and the unused encoding behave identically.
            default:    state_d = i_fault_la[g] ? ANN_ALERT : ANN_NORMAL;
         endcase
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) state_q <= ANN_NORMAL;
         else        state_q <= state_d;
      end

      assign alert[g]      = (state_q == ANN_ALERT);
      assign steady[g]     = (state_q == ANN_STEADY);
      assign enter[g]      = !alert[g] && !steady[g] && i_fault_la[g];
      assign nxt_normal[g] = (state_d == ANN_NORMAL);
   end

   // Lowest-index entering channel wins a tie.
   assign enter_low = enter & (~enter + N_CH'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)               first_q <= '0;
      else if (&nxt_normal)     first_q <= '0;
      else if (first_q == '0)   first_q <= enter_low;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_lamp        <= '0;
         o_horn        <= 1'b0;
         o_first_out   <= '0;
         o_first_valid <= 1'b0;
      end else begin
         o_lamp        <= {N_CH{lamp_test}} | (alert & {N_CH{flash_phase_q}}) | steady;
         o_horn        <= |alert;
         o_first_out   <= first_q;
         o_first_valid <= |first_q;
      end
   end

endmodule

// File: tb/tb_rpsc_annunciator.sv
// Self-checking bench for rpsc_annunciator with FLASH_HALF=4, SYNC_STG=2.
// Vector table with a scoreboard queue, plus hand-written multi-cycle sequences.
module tb_rpsc_annunciator;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] i_fault_la;
   logic       i_ack;
   logic       i_lamp_test;
   logic [7:0] o_lamp;
   logic       o_horn;
   logic [7:0] o_first_out;
   logic       o_first_valid;

   int n_checks = 0;
   int n_fail   = 0;
   int k        = 0;   // clk edges since reset release

   typedef struct {
      logic [7:0] fault;
      logic       ack;
      logic       lt;
      int         n;
      logic [7:0] lamp;
      logic [7:0] lamp_mask;
      logic       horn;
      logic [7:0] fo;
      logic       fv;
      string      name;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   rpsc_annunciator #(.N_CH(8), .FLASH_HALF(4), .SYNC_STG(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_fault_la    (i_fault_la),
      .i_ack         (i_ack),
      .i_lamp_test   (i_lamp_test),
      .o_lamp        (o_lamp),
      .o_horn        (o_horn),
      .o_first_out   (o_first_out),
      .o_first_valid (o_first_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (k=%0d)", name, act, exp, k);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      k++;
      @(negedge clk);
   endtask

   // Flash phase after edge kk, counted from reset release.
   function automatic logic phase(input int kk);
      return ((kk / 4) % 2) == 1;
   endfunction

   task automatic check_all_zero(input string name);
      check({name, "_lamp"}, o_lamp, 0);
      check({name, "_horn"}, o_horn, 0);
      check({name, "_fo"},   o_first_out, 0);
      check({name, "_fv"},   o_first_valid, 0);
   endtask

   task automatic do_reset();
      reset       = 1'b0;
      i_fault_la  = '0;
      i_ack       = 1'b0;
      i_lamp_test = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      k = 0;
   endtask

   task automatic add(input logic [7:0] fault, input logic ack, input int n,
                      input logic [7:0] lamp, input logic [7:0] mask, input logic horn,
                      input logic [7:0] fo, input logic fv, input string name);
      vec_t v;
      v.fault = fault; v.ack = ack; v.lt = 1'b0; v.n = n;
      v.lamp = lamp; v.lamp_mask = mask; v.horn = horn; v.fo = fo; v.fv = fv; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      vec_t e;

      // Steady / acknowledge sequence on ch2, then first-out on ch4/ch5/ch0/ch7.
      add(8'h04, 0,  1, 8'h00, 8'hFF, 0, 8'h00, 0, "st_latency");
      add(8'h04, 0,  1, 8'h00, 8'hFF, 1, 8'h04, 1, "st_alert");
      add(8'h04, 0,  3, 8'h04, 8'hFF, 1, 8'h04, 1, "st_flash_on");
      add(8'h04, 1,  4, 8'h00, 8'hFF, 1, 8'h04, 1, "st_ack_pending");
      add(8'h04, 1,  1, 8'h04, 8'hFF, 0, 8'h04, 1, "st_acked");
      add(8'h04, 1, 20, 8'h04, 8'hFF, 0, 8'h04, 1, "st_ack_held");
      add(8'h04, 0, 10, 8'h04, 8'hFF, 0, 8'h04, 1, "st_refault");
      add(8'h00, 0,  1, 8'h04, 8'hFF, 0, 8'h04, 1, "st_drop_lat");
      add(8'h00, 0,  1, 8'h00, 8'hFF, 0, 8'h00, 0, "st_dropped");
      add(8'h30, 0,  2, 8'h00, 8'hCF, 1, 8'h10, 1, "fo_tie");
      add(8'h31, 0,  2, 8'h00, 8'hCE, 1, 8'h10, 1, "fo_later");
      add(8'h01, 0,  5, 8'h00, 8'hCE, 1, 8'h10, 1, "fo_lockin");
      add(8'h31, 1,  5, 8'h31, 8'hFF, 0, 8'h10, 1, "fo_acked");
      add(8'h31, 0,  3, 8'h31, 8'hFF, 0, 8'h10, 1, "fo_steady");
      add(8'h01, 0,  2, 8'h01, 8'hFF, 0, 8'h10, 1, "fo_partial");
      add(8'h00, 0,  2, 8'h00, 8'hFF, 0, 8'h00, 0, "fo_cleared");
      add(8'h80, 0,  2, 8'h00, 8'h7F, 1, 8'h80, 1, "fo_relatch");
      add(8'h00, 0,  6, 8'h00, 8'h7F, 1, 8'h80, 1, "fo_hold");

      // Reset mid-ALERT on ch2.
      do_reset();
      check_all_zero("rst_release");
      i_fault_la = 8'h04;
      repeat (3) tick();
      check("rst_pre_horn", o_horn, 1);
      check("rst_pre_fo", o_first_out, 8'h04);
      reset = 1'b0;
      i_fault_la = '0;
      #1;
      check_all_zero("rst_async");
      @(negedge clk);
      @(negedge clk);
      check_all_zero("rst_held");
      reset = 1'b1;
      k = 0;
      check_all_zero("rst_rel2");
      repeat (6) begin
         tick();
         check("rst_after_lamp", o_lamp, 0);
         check("rst_after_horn", o_horn, 0);
      end

      // Table-driven vectors through the scoreboard queue.
      do_reset();
      foreach (vecs[i]) begin
         i_fault_la  = vecs[i].fault;
         i_ack       = vecs[i].ack;
         i_lamp_test = vecs[i].lt;
         sb.push_back(vecs[i]);
         repeat (vecs[i].n) tick();
         e = sb.pop_front();
         if (e.lamp_mask != 8'h00)
            check({e.name, "_lamp"}, o_lamp & e.lamp_mask, e.lamp & e.lamp_mask);
         check({e.name, "_horn"}, o_horn, e.horn);
         check({e.name, "_fo"}, o_first_out, e.fo);
         check({e.name, "_fv"}, o_first_valid, e.fv);
      end

      // Flash: one-cycle fault pulse on ch0 locks in, lamp toggles every 4 clks.
      do_reset();
      i_fault_la = 8'h01;
      tick();
      i_fault_la = 8'h00;
      tick();
      check("fl_horn", o_horn, 1);
      check("fl_fo", o_first_out, 8'h01);
      check("fl_fv", o_first_valid, 1);
      check("fl_lamp0", o_lamp, 8'h00);
      repeat (14) begin
         tick();
         check("fl_lamp", o_lamp, phase(k - 1) ? 8'h01 : 8'h00);
         check("fl_horn_held", o_horn, 1);
      end
      i_ack = 1'b1;
      repeat (4) tick();
      check("fl_ack_lat_horn", o_horn, 1);
      check("fl_ack_lat_fo", o_first_out, 8'h01);
      tick();
      check_all_zero("fl_acked");
      i_ack = 1'b0;

      // Race: ch6 rises on the very edge ack_pulse acknowledges ch1.
      do_reset();
      i_fault_la = 8'h02;
      repeat (2) tick();
      i_ack = 1'b1;
      repeat (3) tick();
      i_fault_la = 8'h42;
      tick();
      check("race_horn_pre", o_horn, 1);
      tick();
      check("race_lamp", o_lamp, 8'h42);
      check("race_horn", o_horn, 1);
      check("race_fo", o_first_out, 8'h02);
      repeat (10) begin
         tick();
         check("race_horn_held", o_horn, 1);
         check("race_ch1_steady", o_lamp & 8'h02, 8'h02);
      end
      i_ack = 1'b0;

      // Lamp test with ch3 in ALERT, then a 50-clk ACK hold.
      do_reset();
      i_fault_la = 8'h08;
      repeat (2) tick();
      check("lt_pre_horn", o_horn, 1);
      i_lamp_test = 1'b1;
      repeat (2) tick();
      check("lt_sync_lat", o_lamp, 8'h00);
      tick();
      check("lt_on", o_lamp, 8'hFF);
      repeat (10) begin
         tick();
         check("lt_lamp", o_lamp, 8'hFF);
         check("lt_horn", o_horn, 1);
         check("lt_fo", o_first_out, 8'h08);
      end
      i_lamp_test = 1'b0;
      repeat (2) tick();
      check("lt_release_lat", o_lamp, 8'hFF);
      repeat (13) begin
         tick();
         check("lt_resume", o_lamp, phase(k - 1) ? 8'h08 : 8'h00);
         check("lt_resume_horn", o_horn, 1);
      end
      i_ack = 1'b1;
      repeat (6) tick();
      check("hold_steady_lamp", o_lamp, 8'h08);
      check("hold_steady_horn", o_horn, 0);
      i_fault_la = 8'h09;
      tick();
      check("hold_new_lat", o_horn, 0);
      repeat (43) begin
         tick();
         check("hold_single_pulse", o_horn, 1);
         check("hold_ch3_steady", o_lamp & 8'h08, 8'h08);
      end
      i_ack = 1'b0;
      repeat (5) tick();
      check("hold_after_horn", o_horn, 1);
      check("hold_after_fo", o_first_out, 8'h08);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
